fetch_regfile: RTL and testbench
================================

FETCH_REGFILE -- requirements
Module: fetch_regfile

Interface
REQ-001 Parameter IMEM_DEPTH, default 256: instruction-memory words, 32-bit each, indexed by pc[7:0].
REQ-002 Parameter HALT_OP, default 6'h3f: opcode in ins[31:26] that stops execution.
REQ-003 clk  input  1  single clock, all state updates on posedge.
REQ-004 rstd  input  1  asynchronous, active-low reset.
REQ-005 ld_en  input  1  instruction-load strobe, honoured in IDLE only.
REQ-006 ld_addr  input  8  instruction-memory word address for load.
REQ-007 ld_data  input  32  instruction word for load.
REQ-008 start  input  1  IDLE->RUN request; HALT->IDLE request.
REQ-009 nextpc  input  32  next program counter from execute stage.
REQ-010 wra  input  5  write-back register address from execute stage; 0 = no write.
REQ-011 result  input  32  write-back data from execute stage.
REQ-012 ins  output  32  current instruction word.
REQ-013 pc  output  32  current program counter (word address).
REQ-014 reg1  output  32  register file read of ins[25:21] (rs).
REQ-015 reg2  output  32  register file read of ins[20:16] (rt).
REQ-016 state  output  2  0 = IDLE, 1 = RUN, 2 = HALT; 3 is never driven.
REQ-017 cycles  output  32  count of executed RUN cycles.

Function
REQ-018 ins SHALL be imem[pc[7:0]], combinational; pc values of 256 and above wrap on the low 8 bits.
REQ-019 reg1/reg2 SHALL be combinational reads of a 32x32 register file; any read of r0 SHALL return 0.
REQ-020 IDLE: ld_en=1 SHALL write ld_data to imem[ld_addr] at posedge; pc and register file SHALL hold.
REQ-021 IDLE: start=1 with ld_en=0 SHALL move to RUN at the next posedge; ld_en=1 and start=1 together SHALL perform the load only and stay in IDLE.
REQ-022 RUN, ins[31:26] != HALT_OP: each posedge SHALL load pc <= nextpc, write regfile[wra] <= result when wra != 0, and increment cycles.
REQ-023 RUN, ins[31:26] == HALT_OP: at that posedge pc, register file and cycles SHALL hold, and state SHALL move to HALT.
REQ-024 RUN and HALT SHALL ignore ld_en; imem SHALL be unchanged in those states.
REQ-025 wra == 0 SHALL never modify any register; r0 SHALL stay 0.
REQ-026 A register written at edge N SHALL appear on reg1/reg2 immediately after edge N, with no bypass required within the same cycle.
REQ-027 cycles SHALL saturate at 32'hffffffff and not wrap.
REQ-028 HALT: start=1 SHALL move to IDLE at the next posedge with pc <= 0 and cycles <= 0; register file and imem SHALL be kept.
REQ-029 HALT with start=0 SHALL hold every output.
REQ-030 Instruction-memory contents SHALL be undefined until loaded; no reset of imem is required.

Reset
REQ-031 rstd=0 SHALL immediately force state=IDLE, pc=0, cycles=0, and all 32 registers to 0, independent of clk.
REQ-032 Reset asserted mid-RUN SHALL abort execution; no register or imem write SHALL occur on an edge while rstd=0.
REQ-033 After rstd returns to 1, the first active edge SHALL behave as IDLE.

Verification
REQ-034 Reset, then load imem[0..2] with 32'h04010005, 32'h04020003, 32'hfc000000, then pulse start, with the execute stage connected -> r1=5 and r2=3 after 2 RUN cycles, state=2, pc=2, cycles=2.
REQ-035 RUN with wra=0 and result=32'hdeadbeef -> reg1 for ins[25:21]=0 stays 0, and no register changes.
REQ-036 IDLE with ld_en=1 and start=1 on the same edge -> imem written, state stays 0; start alone on the next edge -> state=1.
REQ-037 Assert rstd=0 between edges mid-RUN -> pc=0, state=0, r1..r31=0 without a clock edge; ld_en is ignored while in RUN.
REQ-038 HALT, then start=1 -> state=0, pc=0, cycles=0, and r1=5 retained; a reload of imem and rerun works.
REQ-039 Force cycles to 32'hfffffffe in RUN -> two more non-halt edges leave cycles=32'hffffffff.

Source files
------------

// File: rtl/fetch_regfile.sv
// Fetch stage with instruction memory, 32x32 register file and an IDLE/RUN/HALT sequencer.
// The execute stage closes the loop externally through nextpc/wra/result.
module fetch_regfile #(
  parameter int         IMEM_DEPTH = 256,
  parameter logic [5:0] HALT_OP    = 6'h3f
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic        ld_en,
  input  logic [7:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic        start,
  input  logic [31:0] nextpc,
  input  logic [4:0]  wra,
  input  logic [31:0] result,
  output logic [31:0] ins,
  output logic [31:0] pc,
  output logic [31:0] reg1,
  output logic [31:0] reg2,
  output logic [1:0]  state,
  output logic [31:0] cycles
);
  localparam int AW = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t      st_q, st_d;
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] rf [32];
  logic [31:0] pc_q, cyc_q;
  logic        halt_ins, run_adv;

  assign ins      = imem[pc_q[AW-1:0]];
  assign halt_ins = (ins[31:26] == HALT_OP);
  assign run_adv  = (st_q == RUN) && !halt_ins;

  // r0 is never written, but the explicit zero keeps the read independent of it.
  assign reg1   = (ins[25:21] == 5'd0) ? 32'd0 : rf[ins[25:21]];
  assign reg2   = (ins[20:16] == 5'd0) ? 32'd0 : rf[ins[20:16]];
  assign pc     = pc_q;
  assign cycles = cyc_q;
  assign state  = st_q;

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) st_q <= IDLE;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (start && !ld_en) st_d = RUN;
      RUN:     if (halt_ins)        st_d = HALT;
      HALT:    if (start)           st_d = IDLE;
      default:                      st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      pc_q  <= 32'd0;
      cyc_q <= 32'd0;
    end else if (run_adv) begin
      pc_q  <= nextpc;
      cyc_q <= (cyc_q == 32'hffff_ffff) ? cyc_q : cyc_q + 32'd1;
    end else if (st_q == HALT && start) begin
      pc_q  <= 32'd0;
      cyc_q <= 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (run_adv && wra != 5'd0) begin
      rf[wra] <= result;
    end
  end

  // imem has no reset; the rstd term blocks loads on edges seen while reset is held.
  always_ff @(posedge clk) begin
    if (rstd && st_q == IDLE && ld_en) imem[ld_addr[AW-1:0]] <= ld_data;
  end
endmodule

// File: tb/tb_fetch_regfile.sv
// Directed bench for fetch_regfile; a tiny addi-only execute stage closes the loop.
module tb_fetch_regfile;
  logic        clk, rstd, ld_en, start;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data, nextpc, result, ins, pc, reg1, reg2, cycles;
  logic [4:0]  wra;
  logic [1:0]  state;

  logic        exec_on;
  logic [31:0] man_nextpc, man_result;
  logic [4:0]  man_wra;
  int          n_tests, n_fail;

  fetch_regfile dut (
    .clk(clk), .rstd(rstd), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .nextpc(nextpc), .wra(wra), .result(result),
    .ins(ins), .pc(pc), .reg1(reg1), .reg2(reg2), .state(state), .cycles(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Opcode 1 = addi rt, rs, simm16; anything else writes nothing.
  always_comb begin
    if (exec_on) begin
      nextpc = pc + 32'd1;
      wra    = (ins[31:26] == 6'h01) ? ins[20:16] : 5'd0;
      result = reg1 + {{16{ins[15]}}, ins[15:0]};
    end else begin
      nextpc = man_nextpc;
      wra    = man_wra;
      result = man_result;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rstd = 1'b0;
    #3;
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_tests++; if (pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %h want 0", pc); end
    n_tests++; if (cycles !== 32'd0) begin n_fail++; $display("FAIL reset_cycles got %h want 0", cycles); end
    tick();
    rstd = 1'b1;
  endtask

  task automatic test_program();
    exec_on = 1'b1;
    load(8'd0, 32'h04010005);
    load(8'd1, 32'h04020003);
    load(8'd2, 32'hfc000000);
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL prog_idle_after_load got %0d want 0", state); end
    pulse_start();
    n_tests++; if (state !== 2'd1 || pc !== 32'd0) begin n_fail++; $display("FAIL prog_enter_run got st=%0d pc=%h want st=1 pc=0", state, pc); end
    tick();
    n_tests++; if (pc !== 32'd1 || cycles !== 32'd1) begin n_fail++; $display("FAIL prog_step1 got pc=%h cyc=%h want 1/1", pc, cycles); end
    tick();
    tick();
    n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL prog_halt_state got %0d want 2", state); end
    n_tests++; if (pc !== 32'd2) begin n_fail++; $display("FAIL prog_halt_pc got %h want 2", pc); end
    n_tests++; if (cycles !== 32'd2) begin n_fail++; $display("FAIL prog_halt_cycles got %h want 2", cycles); end
  endtask

  task automatic test_halt_restart();
    tick();
    tick();
    n_tests++; if (state !== 2'd2 || pc !== 32'd2 || cycles !== 32'd2) begin n_fail++; $display("FAIL halt_hold got st=%0d pc=%h cyc=%h want 2/2/2", state, pc, cycles); end
    pulse_start();
    n_tests++; if (state !== 2'd0 || pc !== 32'd0 || cycles !== 32'd0) begin n_fail++; $display("FAIL halt_to_idle got st=%0d pc=%h cyc=%h want 0/0/0", state, pc, cycles); end
    load(8'd0, 32'h00220000);
    n_tests++; if (reg1 !== 32'd5) begin n_fail++; $display("FAIL keep_r1 got %h want 5", reg1); end
    n_tests++; if (reg2 !== 32'd3) begin n_fail++; $display("FAIL keep_r2 got %h want 3", reg2); end
    load(8'd0, 32'h04230007);
    load(8'd1, 32'hfc000000);
    pulse_start();
    tick();
    tick();
    n_tests++; if (state !== 2'd2 || pc !== 32'd1 || cycles !== 32'd1) begin n_fail++; $display("FAIL rerun_halt got st=%0d pc=%h cyc=%h want 2/1/1", state, pc, cycles); end
    pulse_start();
    load(8'd0, 32'h00600000);
    n_tests++; if (reg1 !== 32'd12) begin n_fail++; $display("FAIL rerun_r3 got %h want c", reg1); end
    n_tests++; if (reg2 !== 32'd0) begin n_fail++; $display("FAIL r0_read got %h want 0", reg2); end
  endtask

  task automatic test_ld_start();
    ld_en = 1'b1; ld_addr = 8'd0; ld_data = 32'hfc000000; start = 1'b1;
    tick();
    ld_en = 1'b0;
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL ldstart_state got %0d want 0", state); end
    n_tests++; if (ins !== 32'hfc000000) begin n_fail++; $display("FAIL ldstart_write got %h want fc000000", ins); end
    tick();
    start = 1'b0;
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL start_alone got %0d want 1", state); end
    tick();
    n_tests++; if (state !== 2'd2 || pc !== 32'd0 || cycles !== 32'd0) begin n_fail++; $display("FAIL halt_at_pc0 got st=%0d pc=%h cyc=%h want 2/0/0", state, pc, cycles); end
    pulse_start();
  endtask

  task automatic test_wra0_sat();
    exec_on = 1'b0; man_nextpc = 32'd0; man_wra = 5'd0; man_result = 32'hdeadbeef;
    load(8'd0, 32'h00220000);
    load(8'd1, 32'h00000000);
    pulse_start();
    ld_en = 1'b1; ld_addr = 8'd0; ld_data = 32'hfc000000;
    repeat (3) tick();
    n_tests++; if (ins !== 32'h00220000) begin n_fail++; $display("FAIL run_ld_ignored got %h want 00220000", ins); end
    n_tests++; if (reg1 !== 32'd5 || reg2 !== 32'd3) begin n_fail++; $display("FAIL wra0_regs got %h/%h want 5/3", reg1, reg2); end
    n_tests++; if (cycles !== 32'd3 || pc !== 32'd0) begin n_fail++; $display("FAIL wra0_count got cyc=%h pc=%h want 3/0", cycles, pc); end
    man_nextpc = 32'd1;
    tick();
    n_tests++; if (reg1 !== 32'd0 || pc !== 32'd1) begin n_fail++; $display("FAIL wra0_r0 got reg1=%h pc=%h want 0/1", reg1, pc); end
    man_nextpc = 32'd0;
    tick();
    ld_en = 1'b0;
    force dut.cyc_q = 32'hfffffffe;
    #1;
    release dut.cyc_q;
    tick();
    n_tests++; if (cycles !== 32'hffffffff) begin n_fail++; $display("FAIL sat_step got %h want ffffffff", cycles); end
    tick();
    n_tests++; if (cycles !== 32'hffffffff || state !== 2'd1) begin n_fail++; $display("FAIL sat_hold got cyc=%h st=%0d want ffffffff/1", cycles, state); end
  endtask

  task automatic test_reset_midrun();
    man_wra = 5'd1; man_nextpc = 32'd7;
    #2;
    rstd = 1'b0;
    #1;
    n_tests++; if (state !== 2'd0 || pc !== 32'd0 || cycles !== 32'd0) begin n_fail++; $display("FAIL midrun_reset got st=%0d pc=%h cyc=%h want 0/0/0", state, pc, cycles); end
    n_tests++; if (reg1 !== 32'd0 || reg2 !== 32'd0) begin n_fail++; $display("FAIL midrun_regs got %h/%h want 0/0", reg1, reg2); end
    ld_en = 1'b1; ld_addr = 8'd0; ld_data = 32'hfc000000; start = 1'b1;
    tick();
    tick();
    ld_en = 1'b0; start = 1'b0;
    n_tests++; if (ins !== 32'h00220000 || reg1 !== 32'd0) begin n_fail++; $display("FAIL held_reset_writes got ins=%h reg1=%h want 00220000/0", ins, reg1); end
    rstd = 1'b1;
    tick();
    n_tests++; if (state !== 2'd0 || pc !== 32'd0) begin n_fail++; $display("FAIL post_reset_idle got st=%0d pc=%h want 0/0", state, pc); end
    pulse_start();
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL post_reset_start got %0d want 1", state); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rstd = 1'b0; ld_en = 1'b0; ld_addr = 8'd0; ld_data = 32'd0; start = 1'b0;
    exec_on = 1'b0; man_nextpc = 32'd0; man_wra = 5'd0; man_result = 32'd0;
    test_reset();
    test_program();
    test_halt_restart();
    test_ld_start();
    test_wra0_sat();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
